// File: rtl/engine_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : engine_memory_arbiter
// Purpose  : Round-robin arbiter sharing one instruction-memory read port
//            among 2**REQ_ID_BITS engines. Coalesces same-address requests
//            and broadcasts each completed fill.
// Revision : 1.0
// ============================================================================
module engine_memory_arbiter #(
    parameter int REQ_ID_BITS       = 2,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [2**REQ_ID_BITS-1:0]                       req_valid,
    input  logic [(2**REQ_ID_BITS)*MEMORY_ADDR_WIDTH-1:0]   req_addr,
    output logic [2**REQ_ID_BITS-1:0]                       req_ready,
    output logic [MEMORY_WIDTH-1:0]                         resp_data,
    output logic                                            broadcast_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]                    broadcast_addr,
    output logic                                            mem_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]                    mem_addr,
    input  logic                                            mem_ready,
    input  logic [MEMORY_WIDTH-1:0]                         mem_data,
    output logic                                            busy,
    output logic [31:0]                                     merged_count
);

    localparam int c_num_req = 2**REQ_ID_BITS;
    localparam int c_aw      = MEMORY_ADDR_WIDTH;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [REQ_ID_BITS-1:0]  r_rr_ptr;
    logic [c_aw-1:0]         r_g_addr;
    logic [c_aw-1:0]         r_bcast_addr;
    logic [c_num_req-1:0]    r_g_mask;
    logic [MEMORY_WIDTH-1:0] r_resp_data;
    logic [31:0]             r_merged_count;

    logic                    w_any_req;
    logic                    w_found;
    logic [REQ_ID_BITS-1:0]  w_cand;
    logic [REQ_ID_BITS-1:0]  w_winner;
    logic [c_aw-1:0]         w_win_addr;
    logic [c_num_req-1:0]    w_grant_mask;
    logic [c_num_req-1:0]    w_late_mask;
    logic [REQ_ID_BITS:0]    w_popcount;
    logic [32:0]             w_merged_sum;
    logic [31:0]             w_merged_next;

    // Rotating priority scan starting at the round-robin pointer.
    always_comb begin
        w_any_req = |req_valid;
        w_found   = 1'b0;
        w_cand    = '0;
        w_winner  = r_rr_ptr;
        for (int k = 0; k < c_num_req; k++) begin
            w_cand = r_rr_ptr + REQ_ID_BITS'(k);
            if (!w_found && req_valid[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    assign w_win_addr = req_addr[w_winner*c_aw +: c_aw];

    for (genvar gi = 0; gi < c_num_req; gi++) begin : g_match
        assign w_grant_mask[gi] = req_valid[gi] && (req_addr[gi*c_aw +: c_aw] == w_win_addr);
        assign w_late_mask[gi]  = req_valid[gi] && (req_addr[gi*c_aw +: c_aw] == r_g_addr);

        // A pending requester must not retarget its address.
        a_addr_stable: assert property (@(posedge clk) disable iff (rst)
            (req_valid[gi] && !req_ready[gi]) |=>
            (!req_valid[gi] || $stable(req_addr[gi*c_aw +: c_aw])));
    end

    // Winner itself is always in the mask, so popcount-1 never underflows in RESP.
    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < c_num_req; i++) begin
            w_popcount = w_popcount + {{REQ_ID_BITS{1'b0}}, r_g_mask[i]};
        end
        w_merged_sum  = {1'b0, r_merged_count} + 33'(w_popcount) - 33'd1;
        w_merged_next = w_merged_sum[32] ? '1 : w_merged_sum[31:0];
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_any_req) w_state_next = c_st_wait;
            c_st_wait: if (mem_ready) w_state_next = c_st_resp;
            c_st_resp: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            r_g_addr       <= '0;
            r_g_mask       <= '0;
            r_bcast_addr   <= '0;
            r_resp_data    <= '0;
            r_merged_count <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        r_g_addr <= w_win_addr;
                        r_g_mask <= w_grant_mask;
                        r_rr_ptr <= w_winner + REQ_ID_BITS'(1);
                    end
                end
                c_st_wait: begin
                    if (mem_ready) begin
                        r_resp_data  <= mem_data;
                        r_g_mask     <= r_g_mask | w_late_mask;
                        r_bcast_addr <= r_g_addr;
                    end
                end
                c_st_resp: begin
                    r_merged_count <= w_merged_next;
                end
                default: ;
            endcase
        end
    end

    assign mem_valid       = (r_state == c_st_wait);
    assign mem_addr        = r_g_addr;
    assign req_ready       = (r_state == c_st_resp) ? r_g_mask : '0;
    assign broadcast_valid = (r_state == c_st_resp);
    assign broadcast_addr  = r_bcast_addr;
    assign resp_data       = r_resp_data;
    assign busy            = (r_state != c_st_idle);
    assign merged_count    = r_merged_count;

endmodule
`default_nettype wire

// File: tb/tb_engine_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_engine_memory_arbiter
// Purpose  : Table-driven self-checking bench for engine_memory_arbiter.
// Revision : 1.0
// ============================================================================
module tb_engine_memory_arbiter;

    localparam int c_idb = 2;
    localparam int c_n   = 4;
    localparam int c_aw  = 11;
    localparam int c_dw  = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [c_n-1:0]        req_valid = '0;
    logic [c_n*c_aw-1:0]   req_addr = '0;
    logic [c_n-1:0]        req_ready;
    logic [c_dw-1:0]       resp_data;
    logic                  broadcast_valid;
    logic [c_aw-1:0]       broadcast_addr;
    logic                  mem_valid;
    logic [c_aw-1:0]       mem_addr;
    logic                  mem_ready = 1'b0;
    logic [c_dw-1:0]       mem_data = '0;
    logic                  busy;
    logic [31:0]           merged_count;

    int n_cmp  = 0;
    int n_fail = 0;

    engine_memory_arbiter #(
        .REQ_ID_BITS       (c_idb),
        .MEMORY_WIDTH      (c_dw),
        .MEMORY_ADDR_WIDTH (c_aw)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_ready       (req_ready),
        .resp_data       (resp_data),
        .broadcast_valid (broadcast_valid),
        .broadcast_addr  (broadcast_addr),
        .mem_valid       (mem_valid),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_data        (mem_data),
        .busy            (busy),
        .merged_count    (merged_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                rst_before;
        logic [c_n-1:0]      new_valid;
        logic [c_n*c_aw-1:0] new_addr;
        logic [c_n-1:0]      late_valid;
        logic [c_n*c_aw-1:0] late_addr;
        int                  lat;
        logic [c_dw-1:0]     data;
        logic [c_aw-1:0]     exp_addr;
        logic [c_n-1:0]      exp_ready;
        logic [31:0]         exp_merged;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [c_n*c_aw-1:0] pk(input logic [c_aw-1:0] a0, input logic [c_aw-1:0] a1,
                                               input logic [c_aw-1:0] a2, input logic [c_aw-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic rb, input logic [c_n-1:0] nv, input logic [c_n*c_aw-1:0] na,
                                input logic [c_n-1:0] lv, input logic [c_n*c_aw-1:0] la, input int lat,
                                input logic [c_dw-1:0] d, input logic [c_aw-1:0] ea,
                                input logic [c_n-1:0] er, input logic [31:0] em);
        vec_t v;
        v.rst_before = rb;  v.new_valid = nv;  v.new_addr = na;
        v.late_valid = lv;  v.late_addr = la;  v.lat = lat;
        v.data = d;  v.exp_addr = ea;  v.exp_ready = er;  v.exp_merged = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"},       32'(req_ready), 0);
        check({tag, " resp_data"},       32'(resp_data), 0);
        check({tag, " broadcast_valid"}, 32'(broadcast_valid), 0);
        check({tag, " broadcast_addr"},  32'(broadcast_addr), 0);
        check({tag, " mem_valid"},       32'(mem_valid), 0);
        check({tag, " mem_addr"},        32'(mem_addr), 0);
        check({tag, " busy"},            32'(busy), 0);
        check({tag, " merged_count"},    merged_count, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;  req_valid = '0;  mem_ready = 1'b0;  mem_data = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full access: raise requests, serve memory after v.lat WAIT cycles, check RESP and IDLE.
    task automatic run_txn(input vec_t v, input int idx);
        int waited;
        if (v.rst_before) do_reset();
        for (int i = 0; i < c_n; i++) begin
            if (v.new_valid[i]) begin
                req_valid[i] = 1'b1;
                req_addr[i*c_aw +: c_aw] = v.new_addr[i*c_aw +: c_aw];
            end
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_valid && waited < 20);
        check($sformatf("v%0d mem_valid rise", idx), 32'(mem_valid), 1);
        if (!mem_valid) return;
        check($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.exp_addr));
        check($sformatf("v%0d busy wait", idx), 32'(busy), 1);
        for (int i = 0; i < c_n; i++) begin
            if (v.late_valid[i]) begin
                req_valid[i] = 1'b1;
                req_addr[i*c_aw +: c_aw] = v.late_addr[i*c_aw +: c_aw];
            end
        end
        for (int c = 1; c <= v.lat; c++) begin
            if (c == v.lat) begin
                mem_ready = 1'b1;
                mem_data  = v.data;
            end else begin
                @(negedge clk);
                check($sformatf("v%0d stall mem_valid c%0d", idx, c), 32'(mem_valid), 1);
                check($sformatf("v%0d stall mem_addr c%0d", idx, c), 32'(mem_addr), 32'(v.exp_addr));
                check($sformatf("v%0d stall req_ready c%0d", idx, c), 32'(req_ready), 0);
                check($sformatf("v%0d stall busy c%0d", idx, c), 32'(busy), 1);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_data  = '0;
        check($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'(v.exp_ready));
        check($sformatf("v%0d resp_data", idx), 32'(resp_data), 32'(v.data));
        check($sformatf("v%0d broadcast_valid", idx), 32'(broadcast_valid), 1);
        check($sformatf("v%0d broadcast_addr", idx), 32'(broadcast_addr), 32'(v.exp_addr));
        check($sformatf("v%0d mem_valid resp", idx), 32'(mem_valid), 0);
        req_valid = req_valid & ~v.exp_ready;
        @(negedge clk);
        check($sformatf("v%0d idle req_ready", idx), 32'(req_ready), 0);
        check($sformatf("v%0d idle broadcast_valid", idx), 32'(broadcast_valid), 0);
        check($sformatf("v%0d idle busy", idx), 32'(busy), 0);
        check($sformatf("v%0d idle resp_data hold", idx), 32'(resp_data), 32'(v.data));
        check($sformatf("v%0d idle broadcast_addr hold", idx), 32'(broadcast_addr), 32'(v.exp_addr));
        check($sformatf("v%0d merged_count", idx), merged_count, v.exp_merged);
    endtask

    initial begin
        int waited;

        vecs[0]  = mk(0, 4'b1010, pk(0, 11'h0A1, 0, 11'h0A3), 0, 0, 1, 16'h1A1A, 11'h0A1, 4'b0010, 0);
        vecs[1]  = mk(0, 4'b0000, 0, 0, 0, 1, 16'h3A3A, 11'h0A3, 4'b1000, 0);
        vecs[2]  = mk(0, 4'b0001, pk(11'h010, 0, 0, 0), 0, 0, 2, 16'hBEEF, 11'h010, 4'b0001, 0);
        vecs[3]  = mk(1, 4'b1111, pk(11'h001, 11'h002, 11'h003, 11'h004), 0, 0, 1, 16'h0001, 11'h001, 4'b0001, 0);
        vecs[4]  = mk(0, 4'b0000, 0, 0, 0, 1, 16'h0002, 11'h002, 4'b0010, 0);
        vecs[5]  = mk(0, 4'b0000, 0, 0, 0, 1, 16'h0003, 11'h003, 4'b0100, 0);
        vecs[6]  = mk(0, 4'b0000, 0, 0, 0, 1, 16'h0004, 11'h004, 4'b1000, 0);
        vecs[7]  = mk(0, 4'b0101, pk(11'h005, 0, 11'h007, 0), 0, 0, 1, 16'h0005, 11'h005, 4'b0001, 0);
        vecs[8]  = mk(0, 4'b0000, 0, 0, 0, 1, 16'h0007, 11'h007, 4'b0100, 0);
        vecs[9]  = mk(1, 4'b1110, pk(0, 11'h055, 11'h066, 11'h055), 0, 0, 1, 16'hA55A, 11'h055, 4'b1010, 1);
        vecs[10] = mk(0, 4'b0000, 0, 0, 0, 1, 16'h6666, 11'h066, 4'b0100, 1);
        vecs[11] = mk(1, 4'b0001, pk(11'h020, 0, 0, 0), 4'b0100, pk(0, 0, 11'h020, 0), 2, 16'h2020, 11'h020, 4'b0101, 1);
        vecs[12] = mk(0, 4'b0010, pk(0, 11'h033, 0, 0), 4'b1000, pk(0, 0, 0, 11'h044), 11, 16'h5A5A, 11'h033, 4'b0010, 1);
        vecs[13] = mk(0, 4'b0000, 0, 0, 0, 1, 16'h4444, 11'h044, 4'b1000, 1);
        vecs[14] = mk(0, 4'b0111, pk(11'h077, 11'h077, 11'h077, 0), 0, 0, 1, 16'h7777, 11'h077, 4'b0111, 32'hFFFF_FFFF);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Reset while a memory access is outstanding
        req_valid[1] = 1'b1;
        req_addr[1*c_aw +: c_aw] = 11'h011;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_valid && waited < 20);
        check("midwait mem_valid", 32'(mem_valid), 1);
        check("midwait mem_addr", 32'(mem_addr), 32'h011);
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check_all_zero("midwait reset");
        rst = 1'b0;
        @(negedge clk);
        check("post reset mem_valid", 32'(mem_valid), 0);

        for (int v = 0; v < 14; v++) begin
            run_txn(vecs[v], v);
        end

        // Saturation: preload the counter at its ceiling, then merge two more
        force dut.r_merged_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_merged_count;
        run_txn(vecs[14], 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/engine_memory_arbiter.md
Name: engine_memory_arbiter

Overview:
- Shares one instruction-memory read port among 2**REQ_ID_BITS engines.
- Each engine presents a read request (valid/addr). The arbiter grants one request round-robin and forwards it to memory.
- Every requester waiting on the same address is answered by the single memory access (coalescing). The returned address is broadcast to all engines so their caches can snoop the fill.
- Sits between the vectorial engines' memory ports and the shared instruction memory.

Parameters:
- REQ_ID_BITS, 2, log2 of the number of requesters (N = 2**REQ_ID_BITS).
- MEMORY_WIDTH, 16, instruction word width.
- MEMORY_ADDR_WIDTH, 11, instruction address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  N  per-engine read request
- req_addr  input  N*MEMORY_ADDR_WIDTH  per-engine address; slice i is [i*AW +: AW]
- req_ready  output  N  one-cycle pulse; resp_data is valid for requester i
- resp_data  output  MEMORY_WIDTH  returned word, shared by all requesters
- broadcast_valid  output  1  one-cycle pulse, a fill completed
- broadcast_addr  output  MEMORY_ADDR_WIDTH  address of the completed fill
- mem_valid  output  1  request to memory
- mem_addr  output  MEMORY_ADDR_WIDTH  address to memory
- mem_ready  input  1  memory returns mem_data this cycle; only meaningful while mem_valid
- mem_data  input  MEMORY_WIDTH  memory read data
- busy  output  1  high in WAIT and RESP
- merged_count  output  32  saturating count of requests served without their own memory access

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset values: state=IDLE, rr_ptr=0, and every output 0 (req_ready, resp_data, broadcast_*, mem_*, busy, merged_count).
- Reset mid-operation: any outstanding memory access is abandoned. Memory shares the same rst.
- IDLE:
  - If any req_valid is high, pick winner w = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo N.
  - Register g_addr = req_addr[w]. Register g_mask = all i with req_valid[i] and req_addr[i]==g_addr.
  - Set rr_ptr = (w+1) mod N, wrapping naturally at width REQ_ID_BITS.
  - Go to WAIT. mem_valid=1 and mem_addr=g_addr appear the next cycle, i.e. one cycle of grant latency.
- WAIT:
  - Hold mem_valid=1 and mem_addr=g_addr stable until mem_ready.
  - On mem_ready: capture mem_data into resp_data.
  - Late coalescing: OR into g_mask every i with req_valid[i] and req_addr[i]==g_addr in that same cycle.
  - Go to RESP. mem_valid drops the next cycle.
- RESP, exactly one cycle:
  - req_ready = g_mask.
  - broadcast_valid=1, broadcast_addr=g_addr.
  - resp_data holds the captured word.
  - merged_count += popcount(g_mask)-1, saturating at 2**32-1.
  - Next state IDLE.
  - Requests seen during RESP are not arbitrated; arbitration resumes in IDLE the following cycle.
  - Minimum turnaround per access: 3 cycles, with mem_ready one cycle after mem_valid rises.
- Requester rules:
  - A requester holds req_valid and req_addr until its req_ready pulse.
  - A requester that drops req_valid after being captured in g_mask still receives the req_ready pulse. It must ignore the pulse.
  - Changing req_addr while pending is illegal. Assert this in simulation.
- Outside RESP: req_ready=0, broadcast_valid=0. resp_data and broadcast_addr keep their last values.
- Fairness: a continuously asserting requester waits at most N-1 grants.
- No simultaneous events in IDLE beyond arbitration. Requests and grants never collide with responses because RESP is a distinct state.

Test Plan:
- Single request: reset, req_valid=0001, addr0=0x010; mem_ready 2 cycles after mem_valid with data 0xBEEF -> mem_addr=0x010, then req_ready=0001, resp_data=0xBEEF, broadcast_valid=1, broadcast_addr=0x010, merged_count=0.
- Round-robin: all 4 requesters valid with distinct addrs 0x1,0x2,0x3,0x4 and held until served; memory ready after 1 cycle -> grant order 0,1,2,3. A second round with only req 0 and 2 valid -> order 0,2.
- Coalescing at grant: req 1 and 3 both at addr 0x055, req 2 at 0x066, rr_ptr=0 -> one access to 0x055, req_ready=1010 in the same cycle, merged_count=1. The next access goes to 0x066.
- Late coalescing: req 0 granted at 0x020; req 2 raises valid at 0x020 while in WAIT -> req_ready=0101 on RESP, no second access to 0x020, merged_count=1.
- Stall/hold: mem_ready withheld for 10 cycles -> mem_valid and mem_addr stable for all 10 cycles, busy=1, no req_ready pulses.
- Reset mid-WAIT: assert rst while in WAIT -> next cycle all outputs 0, rr_ptr=0, state IDLE. A later request is served normally. merged_count at 0xFFFFFFFF stays saturated after a further merge.
